// File: rtl/gat_pkg.sv
// Shared types and dataset constants for the GAT accelerator blocks.
// Select the dataset with +define+CITESEER; Cora is the default.
package gat_pkg;

`ifdef CITESEER
   localparam int NUM_SUBGRAPHS   = 3327;
   localparam int NUM_FEATURE_OUT = 6;
`else
   localparam int NUM_SUBGRAPHS   = 2708;
   localparam int NUM_FEATURE_OUT = 16;
`endif

   localparam int NEW_FEATURE_WIDTH = 32;
   localparam int NEW_FEATURE_DEPTH = NUM_SUBGRAPHS * NUM_FEATURE_OUT;

   // Word index to byte address on the BRAM port B.
   localparam int BYTE_SHIFT = 2;

   typedef enum logic [2:0] {
      FR_IDLE,
      FR_WAIT_RDY,
      FR_READ,
      FR_DRAIN,
      FR_FIN
   } feat_rd_state_t;

endpackage

// File: rtl/gat_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module gat_sync_fifo #(
   parameter int  WIDTH = 32,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // A pop frees the slot in the same cycle, so push-on-full is legal with a pop.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/gat_feat_reader.sv
// Drains the new-feature BRAM onto a valid/ready stream once the accelerator is done.
// Reads are credit-limited so every issued read always has a FIFO slot waiting.
module gat_feat_reader #(
   parameter int NEW_FEATURE_WIDTH  = gat_pkg::NEW_FEATURE_WIDTH,
   parameter int NEW_FEATURE_DEPTH  = gat_pkg::NEW_FEATURE_DEPTH,
   parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
   parameter int RD_LATENCY         = 2,
   parameter int FIFO_DEPTH         = 4,
   parameter int CNT_W              = $clog2(NEW_FEATURE_DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          gat_ready,
   output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
   input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
   output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic                          m_tlast,
   output logic                          busy,
   output logic                          done,
   output logic [CNT_W-1:0]              word_cnt
);
   import gat_pkg::*;

   localparam int FC_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BA_W = CNT_W + BYTE_SHIFT;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NEW_FEATURE_DEPTH - 1);
   localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(NEW_FEATURE_DEPTH);

   feat_rd_state_t state_q, state_d;

   logic [CNT_W-1:0]              rd_idx_q, rd_idx_d;
   logic [CNT_W-1:0]              word_cnt_q, word_cnt_d;
   logic [NEW_FEATURE_ADDR_W+1:0] addrb_q, addrb_d;
   logic [BA_W-1:0]               next_byte_addr;
   logic [RD_LATENCY-1:0]         vld_pipe_q;

   logic                          issue, clear, accept, has_credit;
   logic                          fifo_empty, fifo_full;
   logic [FC_W-1:0]               fifo_cnt;
   logic [NEW_FEATURE_WIDTH-1:0]  fifo_head;

   // Reads still in the BRAM pipe already own a FIFO slot.
   assign has_credit = (int'(fifo_cnt) + $countones(vld_pipe_q)) < FIFO_DEPTH;
   assign accept     = m_tvalid & m_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FR_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FR_IDLE:     if (start)                           state_d = FR_WAIT_RDY;
         FR_WAIT_RDY: if (gat_ready)                       state_d = FR_READ;
         FR_READ:     if (issue && (rd_idx_q == LAST_IDX)) state_d = FR_DRAIN;
         FR_DRAIN:    if (word_cnt_d == TOTAL)             state_d = FR_FIN;
         FR_FIN:                                           state_d = FR_IDLE;
         default:                                          state_d = FR_IDLE;
      endcase
   end

   always_comb begin
      issue = 1'b0;
      clear = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_q)
         FR_IDLE:     clear = start;
         FR_WAIT_RDY: busy  = 1'b1;
         FR_READ: begin
            busy  = 1'b1;
            issue = has_credit;
         end
         FR_DRAIN:    busy  = 1'b1;
         FR_FIN:      done  = 1'b1;
         default: ;
      endcase
   end

   // addrb runs one word ahead, so the word being issued is already on the port.
   always_comb begin
      rd_idx_d       = rd_idx_q;
      addrb_d        = addrb_q;
      word_cnt_d     = word_cnt_q;
      next_byte_addr = BA_W'(rd_idx_q + CNT_W'(1)) << BYTE_SHIFT;
      if (clear) begin
         rd_idx_d   = '0;
         addrb_d    = '0;
         word_cnt_d = '0;
      end else begin
         if (issue) begin
            rd_idx_d = rd_idx_q + CNT_W'(1);
            if (rd_idx_q != LAST_IDX) addrb_d = next_byte_addr[NEW_FEATURE_ADDR_W+1:0];
         end
         if (accept) word_cnt_d = word_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_idx_q   <= '0;
         word_cnt_q <= '0;
         addrb_q    <= '0;
         vld_pipe_q <= '0;
      end else begin
         rd_idx_q      <= rd_idx_d;
         word_cnt_q    <= word_cnt_d;
         addrb_q       <= addrb_d;
         vld_pipe_q[0] <= issue;
         for (int i = 1; i < RD_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
   end

   gat_sync_fifo #(
      .WIDTH (NEW_FEATURE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (vld_pipe_q[RD_LATENCY-1]),
      .wdata_i (feat_bram_dout),
      .pop_i   (accept),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always @(posedge clk) begin
      if (rst_n) assert (!(vld_pipe_q[RD_LATENCY-1] && fifo_full && !accept));
   end

   assign feat_bram_addrb = addrb_q;
   assign m_tvalid        = ~fifo_empty;
   assign m_tdata         = fifo_head;
   // The head is always the next unaccepted word, so its index equals word_cnt.
   assign m_tlast         = m_tvalid & (word_cnt_q == LAST_IDX);
   assign word_cnt        = word_cnt_q;

endmodule
